// File: rtl/kyber_pkg.sv
// Shared definitions for the Kyber host loader: request type codes, per-type
// block geometry in source memory, ciphertext index limit and the loader FSM states.
package kyber_pkg;

  localparam logic [3:0] TYPE_NONE = 4'd0;
  localparam logic [3:0] TYPE_R    = 4'd1;
  localparam logic [3:0] TYPE_EK   = 4'd2;
  localparam logic [3:0] TYPE_MSG  = 4'd3;
  localparam logic [3:0] TYPE_AUX  = 4'd4;

  localparam logic [10:0] LEN_R    = 11'd32;
  localparam logic [10:0] LEN_EK   = 11'd1184;
  localparam logic [10:0] LEN_MSG  = 11'd32;
  localparam logic [10:0] LEN_AUX  = 11'd32;

  localparam logic [10:0] BASE_R   = 11'd0;
  localparam logic [10:0] BASE_EK  = 11'd32;
  localparam logic [10:0] BASE_MSG = 11'd1216;
  localparam logic [10:0] BASE_AUX = 11'd1248;

  localparam logic [15:0] CT_INDEX_LIMIT = 16'd272;

  typedef enum logic [2:0] {
    IDLE, WAIT_REQ, FETCH, LOAD, STREAM, FULL, COLLECT, FINISHED
  } state_t;

  function automatic logic is_load_type(input logic [3:0] t);
    return (t >= TYPE_R) && (t <= TYPE_AUX);
  endfunction

  function automatic logic [10:0] block_len(input logic [3:0] t);
    case (t)
      TYPE_R:   return LEN_R;
      TYPE_EK:  return LEN_EK;
      TYPE_MSG: return LEN_MSG;
      TYPE_AUX: return LEN_AUX;
      default:  return 11'd1;
    endcase
  endfunction

  function automatic logic [10:0] src_base(input logic [3:0] t);
    case (t)
      TYPE_R:   return BASE_R;
      TYPE_EK:  return BASE_EK;
      TYPE_MSG: return BASE_MSG;
      TYPE_AUX: return BASE_AUX;
      default:  return 11'd0;
    endcase
  endfunction

  // One served-flag bit per loadable type, bit 0 = R coins.
  function automatic logic [3:0] type_mask(input logic [3:0] t);
    case (t)
      TYPE_R:   return 4'b0001;
      TYPE_EK:  return 4'b0010;
      TYPE_MSG: return 4'b0100;
      TYPE_AUX: return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/kyber_ct_capture.sv
// Ciphertext capture: forwards in-range coefficient pairs from the encryptor
// into the ciphertext buffer write port; out-of-range indices are dropped.
module kyber_ct_capture
  import kyber_pkg::*;
(
  input  logic        en,
  input  logic [15:0] out_index,
  input  logic [15:0] dout_1,
  input  logic [15:0] dout_2,
  output logic        c_we,
  output logic [8:0]  c_addr,
  output logic [31:0] c_wdata
);

  assign c_we    = en && (out_index < CT_INDEX_LIMIT);
  assign c_addr  = c_we ? out_index[8:0] : 9'd0;
  assign c_wdata = c_we ? {dout_2, dout_1} : 32'd0;

endmodule

// File: rtl/kyber_host_loader.sv
// Host-side loader for a Kyber encryptor: serves requested input blocks byte by
// byte from source memory, then captures the produced ciphertext.
module kyber_host_loader
  import kyber_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  input_type,
  input  logic        readin_ok,
  input  logic        done,
  input  logic [15:0] kyber_dout_1,
  input  logic [15:0] kyber_dout_2,
  input  logic [15:0] kyber_out_index,
  output logic [3:0]  data_type,
  output logic        readin,
  output logic        full_in,
  output logic [7:0]  kyber_din,
  output logic [15:0] kyber_in_index,
  output logic [10:0] src_addr,
  input  logic [7:0]  src_rdata,
  output logic        c_we,
  output logic [8:0]  c_addr,
  output logic [31:0] c_wdata,
  output logic        busy,
  output logic        finished,
  output logic        err
);

  state_t      state_reg, state_next;
  logic [3:0]  t_reg, t_next;
  logic [3:0]  last_reg, last_next;
  logic [3:0]  served_reg, served_next;
  logic [10:0] count_reg, count_next;
  logic [7:0]  din_reg, din_next;
  logic        err_reg, err_next;
  logic        serving;
  logic        collect_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      t_reg      <= TYPE_NONE;
      last_reg   <= TYPE_NONE;
      served_reg <= 4'd0;
      count_reg  <= 11'd0;
      din_reg    <= 8'd0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      t_reg      <= t_next;
      last_reg   <= last_next;
      served_reg <= served_next;
      count_reg  <= count_next;
      din_reg    <= din_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    t_next      = t_reg;
    last_next   = last_reg;
    served_next = served_reg;
    count_next  = count_reg;
    din_next    = din_reg;
    err_next    = err_reg;
    case (state_reg)
      IDLE, FINISHED: begin
        if (start) begin
          state_next  = WAIT_REQ;
          served_next = 4'd0;
          last_next   = TYPE_NONE;
          err_next    = 1'b0;
        end
      end
      WAIT_REQ: begin
        // The encryptor may keep presenting the type just served; that is not a new request.
        if (&served_reg) begin
          state_next = COLLECT;
        end else if (is_load_type(input_type) && (input_type != last_reg)) begin
          if (|(served_reg & type_mask(input_type))) begin
            err_next = 1'b1;
          end else begin
            t_next     = input_type;
            count_next = 11'd0;
            state_next = FETCH;
          end
        end
      end
      FETCH, LOAD, STREAM: begin
        if (input_type != t_reg) begin
          err_next   = 1'b1;
          state_next = WAIT_REQ;
        end else if (state_reg == FETCH) begin
          state_next = LOAD;
        end else if (state_reg == LOAD) begin
          din_next   = src_rdata;
          state_next = STREAM;
        end else if (readin_ok) begin
          if (count_reg == block_len(t_reg) - 11'd1) begin
            state_next = FULL;
          end else begin
            count_next = count_reg + 11'd1;
            state_next = FETCH;
          end
        end
      end
      FULL: begin
        served_next = served_reg | type_mask(t_reg);
        last_next   = t_reg;
        state_next  = WAIT_REQ;
      end
      COLLECT: begin
        if (done) state_next = FINISHED;
      end
      default: state_next = IDLE;
    endcase
  end

  assign serving        = (state_reg == FETCH) || (state_reg == LOAD) ||
                          (state_reg == STREAM) || (state_reg == FULL);
  assign data_type      = serving ? t_reg : TYPE_NONE;
  assign readin         = (state_reg == STREAM);
  assign full_in        = (state_reg == FULL);
  assign kyber_din      = din_reg;
  assign kyber_in_index = {5'd0, count_reg};
  assign src_addr       = (state_reg == FETCH) ? (src_base(t_reg) + count_reg) : 11'd0;
  assign busy           = (state_reg != IDLE) && (state_reg != FINISHED);
  assign finished       = (state_reg == FINISHED);
  assign err            = err_reg;
  assign collect_en     = (state_reg == COLLECT);

  kyber_ct_capture u_ct_capture (
    .en        (collect_en),
    .out_index (kyber_out_index),
    .dout_1    (kyber_dout_1),
    .dout_2    (kyber_dout_2),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata)
  );

endmodule

// File: tb/tb_kyber_host_loader.sv
// Randomized bench for kyber_host_loader: a byte-addressed source memory plus a
// block-level reference (base/length tables) and per-cycle ciphertext write rules.
module tb_kyber_host_loader;

  logic        clk = 1'b0;
  logic        reset, start, readin_ok, done;
  logic [3:0]  input_type;
  logic [15:0] kyber_dout_1, kyber_dout_2, kyber_out_index;
  logic [7:0]  src_rdata;
  logic [3:0]  data_type;
  logic        readin, full_in, c_we, busy, finished, err;
  logic [7:0]  kyber_din;
  logic [15:0] kyber_in_index;
  logic [10:0] src_addr;
  logic [8:0]  c_addr;
  logic [31:0] c_wdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] src_mem [0:2047];
  int tb_len  [0:4] = '{0, 32, 1184, 32, 32};
  int tb_base [0:4] = '{0, 0, 32, 1216, 1248};

  always #5 clk = ~clk;

  always @(posedge clk) src_rdata <= src_mem[src_addr];

  kyber_host_loader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .input_type      (input_type),
    .readin_ok       (readin_ok),
    .done            (done),
    .kyber_dout_1    (kyber_dout_1),
    .kyber_dout_2    (kyber_dout_2),
    .kyber_out_index (kyber_out_index),
    .data_type       (data_type),
    .readin          (readin),
    .full_in         (full_in),
    .kyber_din       (kyber_din),
    .kyber_in_index  (kyber_in_index),
    .src_addr        (src_addr),
    .src_rdata       (src_rdata),
    .c_we            (c_we),
    .c_addr          (c_addr),
    .c_wdata         (c_wdata),
    .busy            (busy),
    .finished        (finished),
    .err             (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ctl"},   32'({busy, finished, err, readin, full_in, c_we}), 32'd0);
    check({tag, "_data"},  32'({kyber_din, kyber_in_index}), 32'd0);
    check({tag, "_addr"},  32'({data_type, src_addr, c_addr}), 32'd0);
    check({tag, "_wdata"}, c_wdata, 32'd0);
  endtask

  // Stream bytes 0..stop_at-1 of type t; a full block also checks the end marker.
  task automatic serve(input int t, input int stop_at, input int stall_idx, input bit rand_stall);
    int idx = 0;
    int held = 0;
    int max_addr = 0;
    int budget = stop_at * 12 + 100;
    input_type = 4'(t);
    while (idx < stop_at && budget > 0) begin
      @(negedge clk);
      budget--;
      readin_ok = 1'b0;
      if (int'(src_addr) > max_addr) max_addr = int'(src_addr);
      if (readin) begin
        check("kyber_din", 32'(kyber_din), 32'(src_mem[tb_base[t] + idx]));
        check("kyber_in_index", 32'(kyber_in_index), 32'(idx));
        check("data_type", 32'(data_type), 32'(t));
        if (idx == stall_idx && held < 5) begin
          held++;
        end else if (rand_stall && $urandom_range(0, 3) == 0) begin
          held = held;
        end else begin
          readin_ok = 1'b1;
          idx++;
        end
      end
    end
    check("bytes_accepted", 32'(idx), 32'(stop_at));
    if (stop_at == tb_len[t]) begin
      @(negedge clk);
      readin_ok = 1'b0;
      check("full_in", 32'(full_in), 32'd1);
      check("readin_at_full", 32'(readin), 32'd0);
      check("last_src_addr", 32'(max_addr), 32'(tb_base[t] + tb_len[t] - 1));
      @(negedge clk);
      check("full_in_one_cycle", 32'(full_in), 32'd0);
    end
  endtask

  task automatic ct_drive(input int idx, input int d1, input int d2, input bit fin);
    bit exp_we;
    @(negedge clk);
    kyber_out_index = 16'(idx);
    kyber_dout_1    = 16'(d1);
    kyber_dout_2    = 16'(d2);
    done            = fin;
    #1;
    exp_we = (idx < 272);
    check("c_we", 32'(c_we), 32'(exp_we));
    if (exp_we) begin
      check("c_addr", 32'(c_addr), 32'(idx % 512));
      check("c_wdata", c_wdata, 32'((d2 % 65536) * 65536 + (d1 % 65536)));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int act;
    int budget;
    reset = 1'b1; start = 1'b0; readin_ok = 1'b0; done = 1'b0; input_type = 4'd0;
    kyber_dout_1 = 16'd0; kyber_dout_2 = 16'd0; kyber_out_index = 16'hFFFF;
    for (int i = 0; i < 2048; i++) src_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    reset = 1'b0;

    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    serve(1, 32, -1, 1'b0);
    serve(2, 100, -1, 1'b1);
    @(negedge clk);
    readin_ok = 1'b0;
    input_type = 4'd3;
    @(negedge clk);
    check("err_on_type_change", 32'(err), 32'd1);
    check("readin_dropped", 32'(readin), 32'd0);
    serve(3, 32, -1, 1'b1);
    serve(2, 1184, 7, 1'b0);
    serve(4, 32, -1, 1'b1);
    input_type = 4'd0;

    for (int i = 0; i < 272; i++) begin
      if ($urandom_range(0, 7) == 0)
        ct_drive(int'($urandom_range(272, 65535)), int'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 65535)), 1'b0);
      ct_drive(i, i, i + 1000, 1'b0);
    end
    ct_drive(300, 12, 34, 1'b0);
    ct_drive(5, 5, 1005, 1'b1);
    @(negedge clk);
    done = 1'b0;
    kyber_out_index = 16'hFFFF;
    #1;
    check("finished", 32'(finished), 32'd1);
    check("busy_when_finished", 32'(busy), 32'd0);
    check("no_write_finished", 32'(c_we), 32'd0);
    check("err_sticky", 32'(err), 32'd1);

    pulse_start();
    check("err_cleared_by_start", 32'(err), 32'd0);
    check("finished_cleared", 32'(finished), 32'd0);
    check("busy_session2", 32'(busy), 32'd1);
    serve(1, 32, -1, 1'b1);
    serve(3, 32, -1, 1'b1);
    input_type = 4'd1;
    repeat (3) @(negedge clk);
    check("err_on_rerequest", 32'(err), 32'd1);
    check("rerequest_not_served", 32'({readin, data_type}), 32'd0);

    serve(2, 50, -1, 1'b1);
    @(negedge clk);
    readin_ok = 1'b0;
    budget = 10;
    while (!readin && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("stream_before_reset", 32'(readin), 32'd1);
    reset = 1'b1;
    #1;
    outputs_zero("reset_midstream");
    @(negedge clk);
    reset = 1'b0;
    readin_ok = 1'b1;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || readin || src_addr != 11'd0) act = 1;
    end
    readin_ok = 1'b0;
    check("idle_until_start", 32'(act), 32'd0);

    pulse_start();
    serve(1, 32, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
